// File: rtl/wordle_round_ctrl.sv
// Round sequencer for a four-letter Wordle game: synchronises the enter button,
// commits guesses letter by letter, scores them and drives the display and status flags.
module wordle_round_ctrl #(
  parameter int          MAX_TRIES = 5,
  parameter logic [27:0] SECRET    = 28'b1100000_1001111_1001110_0100100,
  parameter logic [6:0]  BLANK     = 7'b1111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic [6:0]  letter_code,
  input  logic        letter_valid,
  output logic [27:0] disp_o,
  output logic [3:0]  match_o,
  output logic [2:0]  tries_o,
  output logic        win_o,
  output logic        lose_o,
  output logic        bad_letter_o
);

  // state  | meaning
  // IDLE   | waiting for a press to start a game
  // ENTRY  | committing letters into slot 0..3
  // CHECK  | one-cycle scoring of the committed guess
  // REVIEW | scored guess shown, press starts the next guess
  // WIN    | WINS shown, press returns to IDLE
  // LOSE   | LOSE shown, press reveals the secret
  // REVEAL | secret shown, press returns to IDLE
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, REVIEW, WIN, LOSE, REVEAL} state_t;

  localparam logic [27:0] WINS_CODE = 28'b1001001_1001111_1011010_0100100;
  localparam logic [27:0] LOSE_CODE = 28'b1110001_0000001_0100100_0110000;
  localparam logic [2:0]  MAX3      = 3'(MAX_TRIES);

  state_t      state;
  logic [1:0]  slot;
  logic [6:0]  guess [4];
  logic        s1, s2, s3;
  logic        press;
  logic [27:0] disp_next;
  logic [3:0]  match_next;
  logic [2:0]  tries_inc;

  // enter idles high; a press is the first cycle the synchronised level is seen low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= enter;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press     = s3 & ~s2;
  assign tries_inc = (tries_o == MAX3) ? tries_o : tries_o + 3'd1;

  always_comb begin
    disp_next  = {4{BLANK}};
    match_next = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      match_next[i] = (guess[i] == SECRET[27-7*i -: 7]);
    end
    case (state)
      ENTRY: begin
        for (int i = 0; i < 4; i++) begin
          if (i < int'(slot))       disp_next[27-7*i -: 7] = guess[i];
          else if (i == int'(slot)) disp_next[27-7*i -: 7] = letter_code;
          else                      disp_next[27-7*i -: 7] = BLANK;
        end
      end
      CHECK, REVIEW: disp_next = {guess[0], guess[1], guess[2], guess[3]};
      WIN:           disp_next = WINS_CODE;
      LOSE:          disp_next = LOSE_CODE;
      REVEAL:        disp_next = SECRET;
      default:       disp_next = {4{BLANK}};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      slot         <= 2'd0;
      for (int i = 0; i < 4; i++) guess[i] <= BLANK;
      disp_o       <= {4{BLANK}};
      match_o      <= 4'b0000;
      tries_o      <= 3'd0;
      win_o        <= 1'b0;
      lose_o       <= 1'b0;
      bad_letter_o <= 1'b0;
    end else begin
      bad_letter_o <= 1'b0;
      disp_o       <= disp_next;
      case (state)
        IDLE: begin
          if (press) begin
            state <= ENTRY;
            slot  <= 2'd0;
            for (int i = 0; i < 4; i++) guess[i] <= BLANK;
          end
        end
        ENTRY: begin
          if (press) begin
            if (letter_valid) begin
              guess[slot] <= letter_code;
              if (slot == 2'd3) state <= CHECK;
              else              slot  <= slot + 2'd1;
            end else begin
              bad_letter_o <= 1'b1;
            end
          end
        end
        CHECK: begin
          match_o <= match_next;
          if (&match_next) begin
            state <= WIN;
            win_o <= 1'b1;
          end else begin
            tries_o <= tries_inc;
            if (tries_inc == MAX3) begin
              state  <= LOSE;
              lose_o <= 1'b1;
            end else begin
              state <= REVIEW;
            end
          end
        end
        REVIEW: begin
          if (press) begin
            state <= ENTRY;
            slot  <= 2'd0;
            for (int i = 0; i < 4; i++) guess[i] <= BLANK;
          end
        end
        LOSE: begin
          if (press) state <= REVEAL;
        end
        WIN, REVEAL: begin
          if (press) begin
            state   <= IDLE;
            slot    <= 2'd0;
            for (int i = 0; i < 4; i++) guess[i] <= BLANK;
            match_o <= 4'b0000;
            tries_o <= 3'd0;
            win_o   <= 1'b0;
            lose_o  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_round_ctrl.sv
// Directed bench for wordle_round_ctrl: walks a win, a loss, bad letters,
// a held button and asynchronous resets, checking outputs with immediate assertions.
module tb_wordle_round_ctrl;

  localparam logic [6:0]  L_B = 7'b1100000;
  localparam logic [6:0]  L_I = 7'b1001111;
  localparam logic [6:0]  L_T = 7'b1001110;
  localparam logic [6:0]  L_S = 7'b0100100;
  localparam logic [6:0]  L_A = 7'b0001000;
  localparam logic [6:0]  L_E = 7'b0110000;
  localparam logic [6:0]  L_O = 7'b0000001;
  localparam logic [6:0]  BL  = 7'b1111111;
  localparam logic [27:0] ALL_BLANK = 28'hFFFFFFF;
  localparam logic [27:0] SECRET_W  = 28'b1100000_1001111_1001110_0100100;
  localparam logic [27:0] WINS_W    = 28'b1001001_1001111_1011010_0100100;
  localparam logic [27:0] LOSE_W    = 28'b1110001_0000001_0100100_0110000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enter = 1'b1;
  logic [6:0]  letter_code = 7'b1111111;
  logic        letter_valid = 1'b0;
  logic [27:0] disp_o;
  logic [3:0]  match_o;
  logic [2:0]  tries_o;
  logic        win_o, lose_o, bad_letter_o;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  wordle_round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enter        (enter),
    .letter_code  (letter_code),
    .letter_valid (letter_valid),
    .disp_o       (disp_o),
    .match_o      (match_o),
    .tries_o      (tries_o),
    .win_o        (win_o),
    .lose_o       (lose_o),
    .bad_letter_o (bad_letter_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press();
    @(negedge clk) enter = 1'b0;
    repeat (4) @(negedge clk);
    enter = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic put(input logic [6:0] c);
    letter_code  = c;
    letter_valid = 1'b1;
    press();
  endtask

  task automatic guess4(input logic [6:0] a, input logic [6:0] b,
                        input logic [6:0] c, input logic [6:0] d);
    put(a); put(b); put(c); put(d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_disp"},  32'(disp_o),  32'(ALL_BLANK));
    chk({tag, "_match"}, 32'(match_o), 32'h0);
    chk({tag, "_tries"}, 32'(tries_o), 32'h0);
    chk({tag, "_flags"}, {29'h0, win_o, lose_o, bad_letter_o}, 32'h0);
  endtask

  initial begin
    // 1: reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk_reset_vals("idle");

    // 2: winning guess
    press();
    letter_code = L_B;
    @(negedge clk);
    chk("entry0_live", 32'(disp_o), 32'({L_B, BL, BL, BL}));
    guess4(L_B, L_I, L_T, L_S);
    chk("win_match", 32'(match_o), 32'hF);
    chk("win_flag",  32'(win_o),   32'h1);
    chk("win_tries", 32'(tries_o), 32'h0);
    chk("win_lose",  32'(lose_o),  32'h0);
    chk("win_disp",  32'(disp_o),  32'(WINS_W));
    press();
    chk_reset_vals("after_win");

    // 3: wrong guess, only slot 0 differs
    press();
    guess4(L_A, L_I, L_T, L_S);
    chk("g1_match", 32'(match_o), 32'hE);
    chk("g1_tries", 32'(tries_o), 32'h1);
    chk("g1_lose",  32'(lose_o),  32'h0);
    chk("g1_disp",  32'(disp_o),  32'({L_A, L_I, L_T, L_S}));
    press();
    chk("g2_live0", 32'(disp_o), 32'({L_S, BL, BL, BL}));
    chk("g2_match_held", 32'(match_o), 32'hE);

    // 5: bad letter at slot 2, then a long hold commits one letter
    put(L_B);
    put(L_I);
    letter_code  = L_E;
    letter_valid = 1'b0;
    @(negedge clk) enter = 1'b0;
    pulses = 0;
    repeat (10) @(negedge clk) if (bad_letter_o) pulses++;
    enter = 1'b1;
    repeat (4) @(negedge clk);
    chk("bad_pulse_cnt", 32'(pulses), 32'h1);
    chk("bad_slot_kept", 32'(disp_o), 32'({L_B, L_I, L_E, BL}));
    letter_code  = L_T;
    letter_valid = 1'b1;
    @(negedge clk) enter = 1'b0;
    repeat (50) @(negedge clk);
    enter = 1'b1;
    repeat (4) @(negedge clk);
    letter_code = L_A;
    @(negedge clk);
    chk("hold_one_commit", 32'(disp_o), 32'({L_B, L_I, L_T, L_A}));
    put(L_A);
    chk("g2_tries", 32'(tries_o), 32'h2);

    // 4: run out of tries
    press(); guess4(L_E, L_E, L_E, L_E);
    press(); guess4(L_O, L_I, L_O, L_O);
    chk("g4_tries", 32'(tries_o), 32'h4);
    chk("g4_lose",  32'(lose_o),  32'h0);
    press(); guess4(L_A, L_A, L_A, L_S);
    chk("lose_tries", 32'(tries_o), 32'h5);
    chk("lose_flag",  32'(lose_o),  32'h1);
    chk("lose_win",   32'(win_o),   32'h0);
    chk("lose_disp",  32'(disp_o),  32'(LOSE_W));
    press();
    chk("reveal_disp", 32'(disp_o), 32'(SECRET_W));
    chk("reveal_lose", 32'(lose_o), 32'h1);
    chk("reveal_tries", 32'(tries_o), 32'h5);
    press();
    chk_reset_vals("after_reveal");

    // 6a: reset while at slot 3 with a scored guess on record
    press();
    guess4(L_A, L_I, L_A, L_A);
    chk("g6_match", 32'(match_o), 32'h2);
    chk("g6_tries", 32'(tries_o), 32'h1);
    press();
    put(L_B); put(L_I); put(L_T);
    @(negedge clk) reset = 1'b0;
    #1;
    chk_reset_vals("rst_slot3");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 6b: reset during CHECK with enter still held
    press();
    put(L_E); put(L_E); put(L_E);
    letter_code = L_E;
    @(negedge clk) enter = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk_reset_vals("rst_check");
    enter = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk_reset_vals("no_pending_press");
    letter_code = L_O;
    press();
    chk("post_rst_entry0", 32'(disp_o), 32'({L_O, BL, BL, BL}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
